dma_lint_arb: RTL and testbench



---
 rtl/dma_lint_pkg.sv | 11 +
 rtl/dma_lint_id_fifo.sv | 53 +++++
 rtl/dma_lint_arb.sv | 115 +++++++++++
 tb/tb_dma_lint_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_lint_pkg.sv
// Shared definitions for the DMA LINT arbiter: requester ID encoding and default depth.
package dma_lint_pkg;

  typedef enum logic {
    ID_SRC = 1'b0,
    ID_DST = 1'b1
  } lint_id_e;

  localparam int unsigned DEF_OUT_DEPTH = 4;

endpackage

// File: rtl/dma_lint_id_fifo.sv
// In-order record of granted requester IDs; one entry per outstanding transfer.
module dma_lint_id_fifo
  import dma_lint_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_OUT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  lint_id_e                 push_id_i,
  input  logic                     pop_i,
  output lint_id_e                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  lint_id_e        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     cnt;
  logic            do_push, do_pop;

  assign full_o  = (cnt == FULL_CNT);
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= ID_SRC;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_lint_arb.sv
// Round-robin 2:1 LINT arbiter merging DMA source/destination ports, with
// grant locking on stalls and in-order response routing via an ID FIFO.
module dma_lint_arb
  import dma_lint_pkg::*;
#(
  parameter int unsigned DATA_WD   = 32,
  parameter int unsigned ADDR_WD   = 32,
  parameter int unsigned BE_WD     = DATA_WD / 8,
  parameter int unsigned OUT_DEPTH = DEF_OUT_DEPTH
) (
  input  logic               clk_i,
  input  logic               rstn_i,

  input  logic               src_req_i,
  input  logic               src_we_i,
  input  logic [DATA_WD-1:0] src_wdata_i,
  input  logic [BE_WD-1:0]   src_be_i,
  input  logic [ADDR_WD-1:0] src_addr_i,
  output logic               src_gnt_o,
  output logic               src_rvalid_o,
  output logic [DATA_WD-1:0] src_rdata_o,

  input  logic               dst_req_i,
  input  logic               dst_we_i,
  input  logic [DATA_WD-1:0] dst_wdata_i,
  input  logic [BE_WD-1:0]   dst_be_i,
  input  logic [ADDR_WD-1:0] dst_addr_i,
  output logic               dst_gnt_o,
  output logic               dst_rvalid_o,
  output logic [DATA_WD-1:0] dst_rdata_o,

  output logic               lint_req_o,
  output logic               lint_we_o,
  output logic [DATA_WD-1:0] lint_wdata_o,
  output logic [BE_WD-1:0]   lint_be_o,
  output logic [ADDR_WD-1:0] lint_addr_o,
  input  logic               lint_gnt_i,
  input  logic               lint_rvalid_i,
  input  logic [DATA_WD-1:0] lint_rdata_i,

  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

  lint_id_e        owner, last_grant_q, lock_id_q, head_id;
  logic            locked_q, owner_req, xfer, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   count;

  // A stalled request keeps its owner: LINT payload must stay stable until gnt.
  always_comb begin
    owner = ID_SRC;
    if (locked_q)                   owner = lock_id_q;
    else if (src_req_i && dst_req_i) owner = (last_grant_q == ID_DST) ? ID_SRC : ID_DST;
    else if (dst_req_i)             owner = ID_DST;
  end

  always_comb begin
    owner_req    = src_req_i;
    lint_we_o    = src_we_i;
    lint_wdata_o = src_wdata_i;
    lint_be_o    = src_be_i;
    lint_addr_o  = src_addr_i;
    if (owner == ID_DST) begin
      owner_req    = dst_req_i;
      lint_we_o    = dst_we_i;
      lint_wdata_o = dst_wdata_i;
      lint_be_o    = dst_be_i;
      lint_addr_o  = dst_addr_i;
    end
  end

  // Full blocks on the registered count only, keeping rvalid off the req path.
  assign lint_req_o = owner_req & ~fifo_full;
  assign xfer       = lint_req_o & lint_gnt_i;
  assign src_gnt_o  = xfer & (owner == ID_SRC);
  assign dst_gnt_o  = xfer & (owner == ID_DST);

  assign pop          = lint_rvalid_i & (count != '0);
  assign err_o        = lint_rvalid_i & (count == '0);
  assign src_rvalid_o = pop & (head_id == ID_SRC);
  assign dst_rvalid_o = pop & (head_id == ID_DST);
  assign src_rdata_o  = lint_rdata_i;
  assign dst_rdata_o  = lint_rdata_i;
  assign busy_o       = ~fifo_empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      locked_q     <= 1'b0;
      lock_id_q    <= ID_SRC;
      last_grant_q <= ID_DST;
    end else begin
      locked_q  <= lint_req_o & ~lint_gnt_i;
      lock_id_q <= owner;
      if (xfer) last_grant_q <= owner;
    end
  end

  dma_lint_id_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .push_i    (xfer),
    .push_id_i (owner),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

endmodule

// File: tb/tb_dma_lint_arb.sv
// Directed self-checking bench for dma_lint_arb.
module tb_dma_lint_arb;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        src_req_i, src_we_i, dst_req_i, dst_we_i;
  logic [31:0] src_wdata_i, src_addr_i, dst_wdata_i, dst_addr_i;
  logic [3:0]  src_be_i, dst_be_i;
  logic        src_gnt_o, src_rvalid_o, dst_gnt_o, dst_rvalid_o;
  logic [31:0] src_rdata_o, dst_rdata_o;
  logic        lint_req_o, lint_we_o;
  logic [31:0] lint_wdata_o, lint_addr_o;
  logic [3:0]  lint_be_o;
  logic        lint_gnt_i, lint_rvalid_i;
  logic [31:0] lint_rdata_i;
  logic        busy_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  dma_lint_arb #(
    .DATA_WD   (32),
    .ADDR_WD   (32),
    .BE_WD     (4),
    .OUT_DEPTH (4)
  ) dut (
    .clk_i (clk_i), .rstn_i (rstn_i),
    .src_req_i (src_req_i), .src_we_i (src_we_i), .src_wdata_i (src_wdata_i),
    .src_be_i (src_be_i), .src_addr_i (src_addr_i), .src_gnt_o (src_gnt_o),
    .src_rvalid_o (src_rvalid_o), .src_rdata_o (src_rdata_o),
    .dst_req_i (dst_req_i), .dst_we_i (dst_we_i), .dst_wdata_i (dst_wdata_i),
    .dst_be_i (dst_be_i), .dst_addr_i (dst_addr_i), .dst_gnt_o (dst_gnt_o),
    .dst_rvalid_o (dst_rvalid_o), .dst_rdata_o (dst_rdata_o),
    .lint_req_o (lint_req_o), .lint_we_o (lint_we_o), .lint_wdata_o (lint_wdata_o),
    .lint_be_o (lint_be_o), .lint_addr_o (lint_addr_o), .lint_gnt_i (lint_gnt_i),
    .lint_rvalid_i (lint_rvalid_i), .lint_rdata_i (lint_rdata_i),
    .busy_o (busy_o), .err_o (err_o)
  );

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    src_req_i = 0; src_we_i = 0; src_wdata_i = '0; src_be_i = '0; src_addr_i = '0;
    dst_req_i = 0; dst_we_i = 0; dst_wdata_i = '0; dst_be_i = '0; dst_addr_i = '0;
    lint_gnt_i = 0; lint_rvalid_i = 0; lint_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn_i = 0;
    step();
    rstn_i = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 0;
    #3;
    vectors++;
    if ({lint_req_o, src_gnt_o, dst_gnt_o, src_rvalid_o, dst_rvalid_o, busy_o, err_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0000000",
               {lint_req_o, src_gnt_o, dst_gnt_o, src_rvalid_o, dst_rvalid_o, busy_o, err_o});
    end
    step();
    rstn_i = 1;
    step();
  endtask

  task automatic test_single_read();
    src_req_i = 1; src_addr_i = 32'h100; src_be_i = 4'hF; lint_gnt_i = 1;
    #1;
    vectors++;
    if ({lint_req_o, lint_we_o, src_gnt_o, dst_gnt_o, lint_addr_o} !== {4'b1010, 32'h100}) begin
      miscompares++;
      $display("FAIL single_grant got req/we/sg/dg=%b addr=%h want 1010 addr=00000100",
               {lint_req_o, lint_we_o, src_gnt_o, dst_gnt_o}, lint_addr_o);
    end
    step();
    src_req_i = 0; lint_gnt_i = 0;
    #1;
    vectors++;
    if ({busy_o, lint_req_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_busy got busy/req=%b want 10", {busy_o, lint_req_o});
    end
    step();
    lint_rvalid_i = 1; lint_rdata_i = 32'hDEADBEEF;
    #1;
    vectors++;
    if ({src_rvalid_o, dst_rvalid_o, err_o} !== 3'b100 || src_rdata_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_rvalid got sv/dv/err=%b data=%h want 100 data=deadbeef",
               {src_rvalid_o, dst_rvalid_o, err_o}, src_rdata_o);
    end
    step();
    lint_rvalid_i = 0;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle got busy=%b want 0", busy_o);
    end
  endtask

  // Tie alternation, then full blocking and one-rvalid release, then in-order drain.
  task automatic test_round_robin_full();
    logic [1:0] exp_rv [5];
    exp_rv[0] = 2'b10; exp_rv[1] = 2'b01; exp_rv[2] = 2'b10;
    exp_rv[3] = 2'b01; exp_rv[4] = 2'b10;
    do_reset();
    src_req_i = 1; dst_req_i = 1; lint_gnt_i = 1;
    src_addr_i = 32'h1000; dst_addr_i = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if ({lint_req_o, src_gnt_o, dst_gnt_o} !== {1'b1, k % 2 == 0, k % 2 == 1}) begin
        miscompares++;
        $display("FAIL rr_grant[%0d] got req/sg/dg=%b want %b", k,
                 {lint_req_o, src_gnt_o, dst_gnt_o}, {1'b1, k % 2 == 0, k % 2 == 1});
      end
      step();
    end
    #1;
    vectors++;
    if ({lint_req_o, src_gnt_o, dst_gnt_o, busy_o} !== 4'b0001) begin
      miscompares++;
      $display("FAIL full_block got req/sg/dg/busy=%b want 0001",
               {lint_req_o, src_gnt_o, dst_gnt_o, busy_o});
    end
    lint_rvalid_i = 1; lint_rdata_i = 32'h11;
    #1;
    vectors++;
    if ({lint_req_o, src_gnt_o, dst_gnt_o, exp_rv[0]} !== {3'b000, src_rvalid_o, dst_rvalid_o}) begin
      miscompares++;
      $display("FAIL full_pop_same_cycle got req/sg/dg/sv/dv=%b want 00010",
               {lint_req_o, src_gnt_o, dst_gnt_o, src_rvalid_o, dst_rvalid_o});
    end
    step();
    lint_rvalid_i = 0;
    #1;
    vectors++;
    if ({lint_req_o, src_gnt_o, dst_gnt_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL full_release got req/sg/dg=%b want 110", {lint_req_o, src_gnt_o, dst_gnt_o});
    end
    step();
    src_req_i = 0; dst_req_i = 0; lint_gnt_i = 0;
    for (int k = 1; k < 5; k++) begin
      lint_rvalid_i = 1; lint_rdata_i = 32'h100 + k;
      #1;
      vectors++;
      if ({src_rvalid_o, dst_rvalid_o, err_o} !== {exp_rv[k], 1'b0} || dst_rdata_o !== 32'h100 + k) begin
        miscompares++;
        $display("FAIL drain[%0d] got sv/dv/err=%b data=%h want %b0 data=%h", k,
                 {src_rvalid_o, dst_rvalid_o, err_o}, dst_rdata_o, exp_rv[k], 32'h100 + k);
      end
      step();
    end
    lint_rvalid_i = 0;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    dst_req_i = 1; dst_we_i = 1; dst_addr_i = 32'h200; dst_wdata_i = 32'hCAFE0001; dst_be_i = 4'h3;
    src_addr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) src_req_i = 1;
      #1;
      vectors++;
      if ({lint_req_o, lint_we_o, src_gnt_o, dst_gnt_o, lint_addr_o} !== {4'b1100, 32'h200}
          || lint_wdata_o !== 32'hCAFE0001 || lint_be_o !== 4'h3) begin
        miscompares++;
        $display("FAIL lock_hold[%0d] got req/we/sg/dg=%b addr=%h wd=%h be=%h want 1100 addr=00000200",
                 k, {lint_req_o, lint_we_o, src_gnt_o, dst_gnt_o}, lint_addr_o, lint_wdata_o, lint_be_o);
      end
      step();
    end
    lint_gnt_i = 1;
    #1;
    vectors++;
    if ({src_gnt_o, dst_gnt_o, lint_addr_o} !== {2'b01, 32'h200}) begin
      miscompares++;
      $display("FAIL lock_grant got sg/dg=%b addr=%h want 01 addr=00000200",
               {src_gnt_o, dst_gnt_o}, lint_addr_o);
    end
    step();
    dst_req_i = 0;
    #1;
    vectors++;
    if ({src_gnt_o, dst_gnt_o, lint_addr_o} !== {2'b10, 32'h300}) begin
      miscompares++;
      $display("FAIL lock_next_src got sg/dg=%b addr=%h want 10 addr=00000300",
               {src_gnt_o, dst_gnt_o}, lint_addr_o);
    end
    step();
    src_req_i = 0; lint_gnt_i = 0; lint_rvalid_i = 1;
    #1;
    vectors++;
    if ({src_rvalid_o, dst_rvalid_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_resp0 got sv/dv=%b want 01", {src_rvalid_o, dst_rvalid_o});
    end
    step();
    #1;
    vectors++;
    if ({src_rvalid_o, dst_rvalid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_resp1 got sv/dv=%b want 10", {src_rvalid_o, dst_rvalid_o});
    end
    step();
    lint_rvalid_i = 0;
  endtask

  task automatic test_err();
    idle_inputs();
    step();
    lint_rvalid_i = 1;
    #1;
    vectors++;
    if ({err_o, src_rvalid_o, dst_rvalid_o, busy_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL err_pulse got err/sv/dv/busy=%b want 1000",
               {err_o, src_rvalid_o, dst_rvalid_o, busy_o});
    end
    step();
    lint_rvalid_i = 0;
    #1;
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got err=%b want 0", err_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_req_i = 1; dst_req_i = 1; lint_gnt_i = 1;
    for (int k = 0; k < 3; k++) step();
    src_req_i = 0; dst_req_i = 0; lint_gnt_i = 0;
    #1;
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before got busy=%b want 1", busy_o);
    end
    rstn_i = 0;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_busy_after got busy=%b want 0", busy_o);
    end
    step();
    rstn_i = 1; lint_rvalid_i = 1;
    #1;
    vectors++;
    if ({err_o, src_rvalid_o, dst_rvalid_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL midrst_err got err/sv/dv=%b want 100", {err_o, src_rvalid_o, dst_rvalid_o});
    end
    step();
    lint_rvalid_i = 0; src_req_i = 1; dst_req_i = 1; lint_gnt_i = 1;
    #1;
    vectors++;
    if ({src_gnt_o, dst_gnt_o, err_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL midrst_tie got sg/dg/err=%b want 100", {src_gnt_o, dst_gnt_o, err_o});
    end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn_i = 1;
    #2;
    test_reset();
    test_single_read();
    test_round_robin_full();
    test_lock();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
